// File: rtl/sensor_scan_scheduler_pkg.sv
// Shared definitions for the sensor scan scheduler and its round-robin helper.
//   State encoding (3-bit) for the scan FSM, default conversion timeout,
//   and the width of the conversion timeout timer.
package sensor_scan_scheduler_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SELECT = 3'd1;
   localparam logic [2:0] ST_START  = 3'd2;
   localparam logic [2:0] ST_WAIT   = 3'd3;
   localparam logic [2:0] ST_STORE  = 3'd4;
   localparam logic [2:0] ST_NEXT   = 3'd5;

   localparam int unsigned DEFAULT_TIMEOUT_TICKS = 8;
   // Timeout limit is at most 255, so an 8-bit timer always suffices
   localparam int unsigned TIMER_W = 8;

endpackage

// File: rtl/sensor_scan_scheduler_rr_next_sel.sv
// Round-robin selector: first set mask bit at or after ptr, wrapping at N_CH.
//   ptr        : starting channel index
//   mask       : candidate channels (1 = eligible)
//   next_idx_c : selected index (0 when nothing found)
//   found_c    : at least one mask bit set
module rr_next_sel #(
   parameter int unsigned N_CH = 4,
   parameter int unsigned CH_W = 2
) (
   input  logic [CH_W-1:0] ptr,
   input  logic [N_CH-1:0] mask,
   output logic [CH_W-1:0] next_idx_c,
   output logic            found_c
);

   logic [CH_W:0] cand;

   // Scan offsets from farthest to nearest so the nearest hit is the last one written
   always_comb begin
      next_idx_c = '0;
      found_c    = 1'b0;
      cand       = '0;
      for (int k = int'(N_CH) - 1; k >= 0; k--) begin
         cand = {1'b0, ptr} + (CH_W+1)'(k);
         if (cand >= (CH_W+1)'(N_CH)) cand = cand - (CH_W+1)'(N_CH);
         if (mask[CH_W'(cand)]) begin
            next_idx_c = CH_W'(cand);
            found_c    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sensor_scan_scheduler.sv
// Round-robin scheduler sharing one ADC among N_CH sensor channels.
//   clk_16ms, rst (async, active-low)
//   run, ch_mask              : scan enable and channel inclusion mask
//   adc_start, adc_ch         : conversion request pulse and channel select
//   adc_done, adc_data        : conversion complete pulse and sample
//   sample_bus, sample_valid  : latched samples and per-channel update pulse
//   chan_enable               : one-hot pulse to the channel's protection FSM
//   timeout_err, err_clr      : sticky per-channel timeout flags and their clear
//   busy, scan_done           : not idle; end-of-pass pulse
module sensor_scan_scheduler
   import sensor_scan_scheduler_pkg::*;
#(
   parameter int unsigned N_CH          = 4,
   parameter int unsigned DATA_W        = 12,
   parameter int unsigned CH_W          = 2,
   parameter int unsigned TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS
) (
   input  logic                     clk_16ms,
   input  logic                     rst,
   input  logic                     run,
   input  logic [N_CH-1:0]          ch_mask,
   output logic                     adc_start,
   output logic [CH_W-1:0]          adc_ch,
   input  logic                     adc_done,
   input  logic [DATA_W-1:0]        adc_data,
   output logic [N_CH*DATA_W-1:0]   sample_bus,
   output logic [N_CH-1:0]          sample_valid,
   output logic [N_CH-1:0]          chan_enable,
   output logic [N_CH-1:0]          timeout_err,
   input  logic                     err_clr,
   output logic                     busy,
   output logic                     scan_done
);

   localparam int unsigned BUS_W = N_CH * DATA_W;

   logic [2:0]         state_q, state_d;
   logic [CH_W-1:0]    ptr_q, ptr_d;
   logic [CH_W-1:0]    adc_ch_q, adc_ch_d;
   logic [BUS_W-1:0]   sample_bus_q, sample_bus_d;
   logic [N_CH-1:0]    timeout_err_q, timeout_err_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               adc_start_q, adc_start_d;
   logic [N_CH-1:0]    sample_valid_q, sample_valid_d;
   logic [N_CH-1:0]    chan_enable_q, chan_enable_d;
   logic               scan_done_q, scan_done_d;
   logic               busy_q, busy_d;

   logic [CH_W-1:0]    sel_idx_c;
   logic               sel_found_c;
   logic [CH_W-1:0]    mask_top_c;

   rr_next_sel #(
      .N_CH (N_CH),
      .CH_W (CH_W)
   ) u_rr_next_sel (
      .ptr        (ptr_q),
      .mask       (ch_mask),
      .next_idx_c (sel_idx_c),
      .found_c    (sel_found_c)
   );

   // Highest included channel marks the end of a pass
   always_comb begin
      mask_top_c = '0;
      for (int i = 0; i < int'(N_CH); i++) begin
         if (ch_mask[i]) mask_top_c = CH_W'(i);
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      adc_ch_d      = adc_ch_q;
      sample_bus_d  = sample_bus_q;
      timer_d       = timer_q;
      // Clear first so a timeout in the same cycle still sets its bit
      timeout_err_d = err_clr ? '0 : timeout_err_q;

      case (state_q)
         ST_IDLE: begin
            if (run && (|ch_mask)) state_d = ST_SELECT;
         end
         ST_SELECT: begin
            if (sel_found_c) begin
               adc_ch_d = sel_idx_c;
               state_d  = ST_START;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_START: begin
            timer_d = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (adc_done) begin
               for (int i = 0; i < int'(N_CH); i++) begin
                  if (adc_ch_q == CH_W'(i)) sample_bus_d[i*DATA_W +: DATA_W] = adc_data;
               end
               state_d = ST_STORE;
            end else if (timer_q == TIMER_W'(TIMEOUT_TICKS - 1)) begin
               timeout_err_d[adc_ch_q] = 1'b1;
               state_d = ST_NEXT;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         ST_STORE: begin
            state_d = ST_NEXT;
         end
         ST_NEXT: begin
            ptr_d   = (adc_ch_q == CH_W'(N_CH - 1)) ? '0 : adc_ch_q + CH_W'(1);
            state_d = run ? ST_SELECT : ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Pulses are registered against the state being entered so they line up with it
      adc_start_d    = (state_d == ST_START);
      busy_d         = (state_d != ST_IDLE);
      sample_valid_d = '0;
      chan_enable_d  = '0;
      scan_done_d    = 1'b0;
      if (state_d == ST_STORE) begin
         sample_valid_d[adc_ch_q] = 1'b1;
         chan_enable_d[adc_ch_q]  = 1'b1;
      end
      if (state_d == ST_NEXT) scan_done_d = (adc_ch_q == mask_top_c);
   end

   always_ff @(posedge clk_16ms or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         ptr_q          <= '0;
         adc_ch_q       <= '0;
         sample_bus_q   <= '0;
         timeout_err_q  <= '0;
         timer_q        <= '0;
         adc_start_q    <= 1'b0;
         sample_valid_q <= '0;
         chan_enable_q  <= '0;
         scan_done_q    <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         ptr_q          <= ptr_d;
         adc_ch_q       <= adc_ch_d;
         sample_bus_q   <= sample_bus_d;
         timeout_err_q  <= timeout_err_d;
         timer_q        <= timer_d;
         adc_start_q    <= adc_start_d;
         sample_valid_q <= sample_valid_d;
         chan_enable_q  <= chan_enable_d;
         scan_done_q    <= scan_done_d;
         busy_q         <= busy_d;
      end
   end

   assign adc_start    = adc_start_q;
   assign adc_ch       = adc_ch_q;
   assign sample_bus   = sample_bus_q;
   assign sample_valid = sample_valid_q;
   assign chan_enable  = chan_enable_q;
   assign timeout_err  = timeout_err_q;
   assign busy         = busy_q;
   assign scan_done    = scan_done_q;

endmodule

// File: tb/tb_sensor_scan_scheduler.sv
// Self-checking bench for sensor_scan_scheduler: directed scenarios followed by
// randomized conversions, checked against a transaction-level channel model.
module tb_sensor_scan_scheduler;

   localparam int unsigned N_CH          = 4;
   localparam int unsigned DATA_W        = 12;
   localparam int unsigned CH_W          = 2;
   localparam int unsigned TIMEOUT_TICKS = 8;
   localparam int unsigned BUS_W         = N_CH * DATA_W;

   logic                 clk_16ms = 1'b0;
   logic                 rst;
   logic                 run;
   logic [N_CH-1:0]      ch_mask;
   logic                 adc_start;
   logic [CH_W-1:0]      adc_ch;
   logic                 adc_done;
   logic [DATA_W-1:0]    adc_data;
   logic [BUS_W-1:0]     sample_bus;
   logic [N_CH-1:0]      sample_valid;
   logic [N_CH-1:0]      chan_enable;
   logic [N_CH-1:0]      timeout_err;
   logic                 err_clr;
   logic                 busy;
   logic                 scan_done;

   int n_chk = 0;
   int n_err = 0;

   // Reference model state
   logic [DATA_W-1:0] m_samp [N_CH];
   logic [N_CH-1:0]   m_err;
   int                m_ptr;
   int                m_en = 0;
   int                mon_en = 0;
   int                mon_multi = 0;

   sensor_scan_scheduler #(
      .N_CH          (N_CH),
      .DATA_W        (DATA_W),
      .CH_W          (CH_W),
      .TIMEOUT_TICKS (TIMEOUT_TICKS)
   ) dut (
      .clk_16ms     (clk_16ms),
      .rst          (rst),
      .run          (run),
      .ch_mask      (ch_mask),
      .adc_start    (adc_start),
      .adc_ch       (adc_ch),
      .adc_done     (adc_done),
      .adc_data     (adc_data),
      .sample_bus   (sample_bus),
      .sample_valid (sample_valid),
      .chan_enable  (chan_enable),
      .timeout_err  (timeout_err),
      .err_clr      (err_clr),
      .busy         (busy),
      .scan_done    (scan_done)
   );

   always #5 clk_16ms = ~clk_16ms;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_next(input int ptr, input logic [N_CH-1:0] mask);
      for (int k = 0; k < int'(N_CH); k++) begin
         if (mask[(ptr + k) % int'(N_CH)]) return (ptr + k) % int'(N_CH);
      end
      return -1;
   endfunction

   function automatic int model_top(input logic [N_CH-1:0] mask);
      int t;
      t = -1;
      for (int i = 0; i < int'(N_CH); i++) if (mask[i]) t = i;
      return t;
   endfunction

   function automatic logic [BUS_W-1:0] model_bus();
      logic [BUS_W-1:0] b;
      b = '0;
      for (int i = 0; i < int'(N_CH); i++) b[i*DATA_W +: DATA_W] = m_samp[i];
      return b;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < int'(N_CH); i++) m_samp[i] = '0;
      m_err = '0;
      m_ptr = 0;
   endtask

   // Count enable pulses and any cycle with more than one enable bit high
   always @(negedge clk_16ms) begin
      if (rst === 1'b1) begin
         mon_en += $countones(chan_enable);
         if (!$onehot0(chan_enable)) mon_multi++;
      end
   end

   // One conversion: answer in WAIT cycle dly (>= TIMEOUT_TICKS means never).
   // Returns at the NEXT-state negedge (or the following IDLE one if run was dropped).
   task automatic service(input int dly, input logic [DATA_W-1:0] dat, input bit stray,
                          input bit drop_run, input bit clr_last);
      int n;
      int ch;
      n = 0;
      while (adc_start !== 1'b1 && n < 20) begin
         @(negedge clk_16ms);
         n++;
      end
      if (adc_start !== 1'b1) begin
         check("start_seen", 64'(adc_start), 64'(1));
         return;
      end
      ch = model_next(m_ptr, ch_mask);
      check("adc_ch", 64'(adc_ch), 64'(ch));
      if (dly < int'(TIMEOUT_TICKS)) begin
         repeat (dly + 1) @(negedge clk_16ms);
         if (drop_run) run = 1'b0;
         check("ch_hold", 64'(adc_ch), 64'(ch));
         check("start_pulse", 64'(adc_start), 64'(0));
         adc_done = 1'b1;
         adc_data = dat;
         @(negedge clk_16ms);
         adc_done = stray;
         adc_data = ~dat;
         check("chan_enable", 64'(chan_enable), 64'(1) << ch);
         check("sample_valid", 64'(sample_valid), 64'(1) << ch);
         m_samp[ch] = dat;
         m_en++;
         check("bus_store", 64'(sample_bus), 64'(model_bus()));
         @(negedge clk_16ms);
         adc_done = 1'b0;
      end else begin
         if (drop_run) run = 1'b0;
         repeat (TIMEOUT_TICKS) @(negedge clk_16ms);
         if (clr_last) err_clr = 1'b1;
         @(negedge clk_16ms);
         err_clr = 1'b0;
         if (clr_last) m_err = '0;
         m_err[ch] = 1'b1;
      end
      check("scan_done", 64'(scan_done), 64'(ch == model_top(ch_mask)));
      check("timeout_err", 64'(timeout_err), 64'(m_err));
      check("bus_next", 64'(sample_bus), 64'(model_bus()));
      m_ptr = (ch + 1) % int'(N_CH);
      if (drop_run) begin
         @(negedge clk_16ms);
         check("idle_after_drop", 64'(busy), 64'(0));
      end
   endtask

   initial begin
      int n;
      int d;
      bit dr;
      logic [BUS_W-1:0] exp_bus;

      rst = 1'b0; run = 1'b0; ch_mask = '0; adc_done = 1'b0; adc_data = '0; err_clr = 1'b0;
      model_reset();
      repeat (2) @(negedge clk_16ms);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_start", 64'(adc_start), 64'(0));
      check("rst_ch", 64'(adc_ch), 64'(0));
      check("rst_bus", 64'(sample_bus), 64'(0));
      check("rst_err", 64'(timeout_err), 64'(0));
      check("rst_en", 64'(chan_enable | sample_valid), 64'(0));
      check("rst_scan", 64'(scan_done), 64'(0));
      rst = 1'b1;
      @(negedge clk_16ms);

      // Full scan, data 0x100 + channel
      ch_mask = 4'b1111;
      run = 1'b1;
      for (int i = 0; i < 5; i++) service(0, DATA_W'(12'h100 + model_next(m_ptr, ch_mask)), 1'b0, 1'b0, 1'b0);
      exp_bus = {12'h103, 12'h102, 12'h101, 12'h100};
      check("full_scan_bus", 64'(sample_bus), 64'(exp_bus));

      // Masked skip; stray done during STORE on the second conversion
      ch_mask = 4'b1010;
      service(0, DATA_W'(12'h201), 1'b0, 1'b0, 1'b0);
      service(0, DATA_W'(12'h203), 1'b1, 1'b0, 1'b0);
      check("skip_slot0", 64'(sample_bus[11:0]), 64'(12'h100));
      check("skip_slot2", 64'(sample_bus[35:24]), 64'(12'h102));

      // Timeouts, clear colliding with a new set, then a plain clear from IDLE
      ch_mask = 4'b0100;
      service(99, '0, 1'b0, 1'b0, 1'b0);
      service(99, '0, 1'b0, 1'b0, 1'b1);
      service(99, '0, 1'b0, 1'b1, 1'b0);
      err_clr = 1'b1;
      @(negedge clk_16ms);
      err_clr = 1'b0;
      m_err = '0;
      check("err_clr", 64'(timeout_err), 64'(0));

      // Run dropped mid-WAIT on ch1, stray done in IDLE, restart resumes at ch2
      ch_mask = 4'b1111;
      run = 1'b1;
      service(0, DATA_W'(12'h303), 1'b0, 1'b0, 1'b0);
      service(0, DATA_W'(12'h300), 1'b0, 1'b0, 1'b0);
      service(2, DATA_W'(12'h301), 1'b0, 1'b1, 1'b0);
      adc_done = 1'b1;
      adc_data = 12'hABC;
      @(negedge clk_16ms);
      adc_done = 1'b0;
      @(negedge clk_16ms);
      check("stray_idle_bus", 64'(sample_bus), 64'(model_bus()));
      check("stray_idle_busy", 64'(busy), 64'(0));
      run = 1'b1;
      service(1, DATA_W'(12'h302), 1'b0, 1'b0, 1'b0);

      // Asynchronous reset in the middle of WAIT on ch2
      ch_mask = 4'b0100;
      n = 0;
      while (adc_start !== 1'b1 && n < 20) begin
         @(negedge clk_16ms);
         n++;
      end
      check("rst_test_start", 64'(adc_start), 64'(1));
      check("rst_test_ch", 64'(adc_ch), 64'(2));
      @(negedge clk_16ms);
      rst = 1'b0;
      run = 1'b0;
      #1;
      check("arst_busy", 64'(busy), 64'(0));
      check("arst_ch", 64'(adc_ch), 64'(0));
      check("arst_bus", 64'(sample_bus), 64'(0));
      check("arst_pulses", 64'({adc_start, scan_done, chan_enable, sample_valid}), 64'(0));
      model_reset();
      @(negedge clk_16ms);
      rst = 1'b1;
      repeat (3) @(negedge clk_16ms);
      check("idle_hold_busy", 64'(busy), 64'(0));
      check("idle_hold_start", 64'(adc_start), 64'(0));

      // Randomized conversions
      ch_mask = N_CH'($urandom_range(1, (1 << N_CH) - 1));
      run = 1'b1;
      for (int i = 0; i < 40; i++) begin
         d  = int'($urandom_range(0, 10));
         dr = ($urandom_range(0, 7) == 0);
         service(d, DATA_W'($urandom), bit'($urandom_range(0, 1)), dr,
                 ($urandom_range(0, 3) == 0) && (d >= int'(TIMEOUT_TICKS)));
         if ($urandom_range(0, 3) == 0) ch_mask = N_CH'($urandom_range(1, (1 << N_CH) - 1));
         if (dr) run = 1'b1;
      end

      @(negedge clk_16ms);
      check("enable_count", 64'(mon_en), 64'(m_en));
      check("enable_onehot", 64'(mon_multi), 64'(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sensor_scan_scheduler.md
Name: sensor_scan_scheduler

Overview:
- Round-robin scheduler that shares one ADC conversion resource among N_CH sensor channels.
- Per channel: selects the channel, issues a start/done handshake with a timeout, latches the sample, then pulses that channel's per-sensor protection FSM enable so it evaluates the fresh value.
- Sits between the shared ADC front-end and the bank of per-channel relay/protection FSMs. Runs in the clk_16ms domain.

Parameters:
- N_CH, 4, number of sensor channels (2..16)
- DATA_W, 12, ADC sample width
- CH_W, 2, channel index width; must equal clog2(N_CH)
- TIMEOUT_TICKS, 8, max clk_16ms cycles in WAIT before the conversion is declared failed (2..255)

Ports:
- clk_16ms  in  1  system tick clock (16 ms period)
- rst  in  1  asynchronous, active-low reset
- run  in  1  level; scanning allowed while high
- ch_mask  in  N_CH  1 = channel included in scan
- adc_start  out  1  one-cycle conversion request
- adc_ch  out  CH_W  channel being converted; stable from START through end of WAIT
- adc_done  in  1  one-cycle conversion-complete pulse
- adc_data  in  DATA_W  sample, valid with adc_done
- sample_bus  out  N_CH*DATA_W  latched samples, channel k at bits [k*DATA_W +: DATA_W]
- sample_valid  out  N_CH  one-cycle pulse, channel sample updated
- chan_enable  out  N_CH  one-hot one-cycle enable to that channel's protection FSM
- timeout_err  out  N_CH  sticky per-channel conversion-timeout flag
- err_clr  in  1  synchronous clear of all timeout_err bits
- busy  out  1  high in any state except IDLE
- scan_done  out  1  one-cycle pulse at the end of each full pass

Behaviour:
- Reset (rst low, async): state IDLE; ptr=0; adc_ch=0; sample_bus=0; timeout_err=0; timer=0. All pulses (adc_start, sample_valid, chan_enable, scan_done) are 0 and busy=0.
- States: IDLE, SELECT, START, WAIT, STORE, NEXT.
- IDLE:
  - run=1 and ch_mask≠0 -> SELECT.
  - Otherwise remain in IDLE.
- SELECT:
  - adc_ch <= first index i ≥ ptr (modulo N_CH, wrapping) with ch_mask[i]=1.
  - Mask is sampled in this cycle only.
  - If the mask became 0 -> IDLE.
  - Otherwise -> START.
- START: adc_start=1 for exactly this cycle; timer<=0 -> WAIT.
- WAIT:
  - adc_done is sampled only here. A done pulse in any other state is ignored.
  - adc_done=1: latch adc_data into the adc_ch slot of sample_bus -> STORE.
  - Otherwise timer++. When timer reaches TIMEOUT_TICKS-1 with no done: set timeout_err[adc_ch] -> NEXT. The slot is not written and the enable is not pulsed.
- STORE: sample_valid[adc_ch]=1 and chan_enable[adc_ch]=1 for this cycle only -> NEXT.
- NEXT:
  - ptr <= adc_ch+1, wrapping N_CH-1 -> 0.
  - scan_done=1 if adc_ch is the highest set bit of the current ch_mask.
  - run=1 -> SELECT; else -> IDLE.
  - run low mid-scan therefore completes the in-flight conversion first.
- Latency: from adc_done to chan_enable is 1 cycle. Fastest per-channel service is 5 cycles (SELECT, START, WAIT with done in the first cycle, STORE, NEXT).
- Simultaneous err_clr and a new timeout on the same cycle: the set wins for that channel.
- Mask changes mid-conversion take effect at the next SELECT. A masked-out channel keeps its last sample.
- Only one chan_enable bit is ever high at a time.

Decomposition:
- Shared package: state encoding localparams (IDLE..NEXT, 3-bit), DEFAULT_TIMEOUT_TICKS.
- Sub-module rr_next_sel (combinational: ptr, mask -> next index + found flag). Instantiated in SELECT logic and reusable by other round-robin blocks.
- The scheduler is otherwise a single FSM plus a timer and the sample register file.

Test Plan:
- Reset/idle: rst low mid-WAIT with adc_ch=2 -> all outputs zero immediately, busy=0. Release with run=0 -> stays IDLE.
- Full scan: mask=4'b1111, ADC returns done 1 cycle after start with data 0x100+ch. Expect:
  - channels serviced 0,1,2,3,0 in order
  - chan_enable one-hot pulses 1 cycle after each done
  - sample_bus = {0x103,0x102,0x101,0x100}
  - scan_done after ch3
- Masked skip: mask=4'b1010 -> only ch1, ch3 converted; scan_done after ch3; slots 0 and 2 unchanged.
- Timeout: mask=4'b0100, adc_done never asserted with TIMEOUT_TICKS=8 -> timeout_err=4'b0100 after 8 WAIT cycles, no chan_enable. err_clr=1 -> 0.
- Stray done: adc_done pulsed in IDLE and STORE -> no sample written, no state change.
- Run drop: run->0 during WAIT on ch1 -> conversion completes, chan_enable[1] pulses, then IDLE with ptr=2. Restart services ch2 first.
